// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 interrupt controller: register selects
// (mtc0/mfc0 rd field) and bit positions inside SR and Cause.
package cp0_pkg;

    localparam logic [4:0] SEL_SR    = 5'd12;
    localparam logic [4:0] SEL_CAUSE = 5'd13;
    localparam logic [4:0] SEL_EPC   = 5'd14;
    localparam logic [4:0] SEL_PRID  = 5'd15;
    localparam logic [4:0] SEL_ITRIG = 5'd22;

    localparam int IE     = 0;
    localparam int EXL    = 1;
    localparam int IP_LSB = 10;
    localparam int ID_LSB = 28;

endpackage

// File: rtl/cp0_intc_if.sv
// Bundle between the core (controller, datapath, devices) and CP0.
// The CP0 sits on the slave side; the core drives the master side.
interface cp0_intc_if #(
    parameter int NUM_IRQ = 6,
    parameter int PC_W    = 32
);
    logic [PC_W-1:0]    pc_in;
    logic [31:0]        wdata;
    logic [NUM_IRQ-1:0] hwint;
    logic [4:0]         sel;
    logic               we;
    logic               exl_set;
    logic               exl_clr;
    logic               epc_wr;
    logic [31:0]        rdata;
    logic [PC_W-1:0]    epc;
    logic               intreq;
    logic [PC_W-1:0]    vector;
    logic [3:0]         irq_id;

    modport master (
        output pc_in, wdata, hwint, sel, we, exl_set, exl_clr, epc_wr,
        input  rdata, epc, intreq, vector, irq_id
    );

    modport slave (
        input  pc_in, wdata, hwint, sel, we, exl_set, exl_clr, epc_wr,
        output rdata, epc, intreq, vector, irq_id
    );
endinterface

// File: rtl/cp0_intc_irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the
// lowest set index (lowest index = highest priority). id is 0 when idle.
module irq_prio_enc #(
    parameter int NUM_IRQ = 6
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               any,
    output logic [3:0]         id
);

    // Scan from the top down so the lowest set index is the last to land.
    always_comb begin
        any = 1'b0;
        id  = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            any = any | req[i];
            id  = req[i] ? 4'(i) : id;
        end
    end

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor 0 with an integrated interrupt controller: SR/Cause/EPC/
// PRId/ITRIG registers, per-source edge or level sensitivity, fixed
// priority selection and optional vectored handler addresses.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int                 NUM_IRQ      = 6,
    parameter int                 PC_W         = 32,
    parameter logic [PC_W-1:0]    HANDLER_BASE = PC_W'(32'h0000_4180),
    parameter int                 VECTORED     = 0,
    parameter int                 VEC_SHIFT    = 4,
    parameter logic [NUM_IRQ-1:0] TRIG_RESET   = {NUM_IRQ{1'b0}},
    parameter logic [31:0]        PRID         = 32'h0000_0001
) (
    input  logic           clk,
    input  logic           rst,
    cp0_intc_if.slave      bus
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(2'b11);

    // Synchroniser and interrupt state
    logic [NUM_IRQ-1:0] hw_q_r;
    logic [NUM_IRQ-1:0] hw_qq_r;
    logic [NUM_IRQ-1:0] lvl_r;
    logic [NUM_IRQ-1:0] pend_r;
    logic [NUM_IRQ-1:0] itrig_r;

    // Architectural registers
    logic [NUM_IRQ-1:0] im_r;
    logic               ie_r;
    logic               exl_r;
    logic [3:0]         id_r;
    logic [PC_W-1:0]    epc_r;

    // Combinational helpers
    logic [NUM_IRQ-1:0] ip_s;
    logic [NUM_IRQ-1:0] req_s;
    logic [NUM_IRQ-1:0] clr_s;
    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] pend_n_s;
    logic               any_s;
    logic [3:0]         id_s;
    logic               we_sr_s;
    logic               we_cause_s;
    logic               we_epc_s;
    logic               we_itrig_s;
    logic [PC_W-1:0]    wdata_pc_s;
    logic [31:0]        rdata_s;

    assign we_sr_s    = bus.we && (bus.sel == SEL_SR);
    assign we_cause_s = bus.we && (bus.sel == SEL_CAUSE);
    assign we_epc_s   = bus.we && (bus.sel == SEL_EPC);
    assign we_itrig_s = bus.we && (bus.sel == SEL_ITRIG);
    assign wdata_pc_s = PC_W'(bus.wdata);

    // Visible pending bits: sticky latch for edge sources, sampled level otherwise.
    assign ip_s   = (itrig_r & pend_r) | (~itrig_r & lvl_r);
    assign req_s  = ip_s & im_r;
    assign rise_s = hw_q_r & ~hw_qq_r;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req (req_s),
        .any (any_s),
        .id  (id_s)
    );

    // Clear sources for edge pending bits: Cause write-1-to-clear and interrupt entry.
    always_comb begin
        clr_s = {NUM_IRQ{1'b0}};
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_s[i] = (we_cause_s & bus.wdata[IP_LSB + i])
                     | (bus.epc_wr & any_s & (id_s == 4'(i)));
        end
    end

    // Next pending state: a fresh edge beats a clear; level sources keep nothing.
    assign pend_n_s = itrig_r & ((pend_r & ~clr_s) | rise_s);

    // Two-flop input sampling, level capture and sticky edge latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hw_q_r  <= {NUM_IRQ{1'b0}};
            hw_qq_r <= {NUM_IRQ{1'b0}};
            lvl_r   <= {NUM_IRQ{1'b0}};
            pend_r  <= {NUM_IRQ{1'b0}};
        end else begin
            hw_q_r  <= bus.hwint;
            hw_qq_r <= hw_q_r;
            lvl_r   <= hw_q_r;
            pend_r  <= pend_n_s;
        end
    end

    // Trigger-mode register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            itrig_r <= TRIG_RESET;
        end else if (we_itrig_s) begin
            itrig_r <= bus.wdata[NUM_IRQ-1:0];
        end else begin
            itrig_r <= itrig_r;
        end
    end

    // SR interrupt mask and global enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_r <= {NUM_IRQ{1'b0}};
            ie_r <= 1'b0;
        end else if (we_sr_s) begin
            im_r <= bus.wdata[IP_LSB +: NUM_IRQ];
            ie_r <= bus.wdata[IE];
        end else begin
            im_r <= im_r;
            ie_r <= ie_r;
        end
    end

    // EXL: controller set has priority over eret clear, both over mtc0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exl_r <= 1'b0;
        end else if (bus.exl_set) begin
            exl_r <= 1'b1;
        end else if (bus.exl_clr) begin
            exl_r <= 1'b0;
        end else if (we_sr_s) begin
            exl_r <= bus.wdata[EXL];
        end else begin
            exl_r <= exl_r;
        end
    end

    // Cause interrupt ID latched on interrupt entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r <= 4'd0;
        end else if (bus.epc_wr) begin
            id_r <= id_s;
        end else begin
            id_r <= id_r;
        end
    end

    // EPC: interrupt entry wins over a simultaneous mtc0; always word aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_r <= {PC_W{1'b0}};
        end else if (bus.epc_wr) begin
            epc_r <= bus.pc_in & ALIGN_MASK;
        end else if (we_epc_s) begin
            epc_r <= wdata_pc_s & ALIGN_MASK;
        end else begin
            epc_r <= epc_r;
        end
    end

    // mfc0 read mux; unmapped selects read as zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (bus.sel)
            SEL_SR: begin
                rdata_s[IP_LSB +: NUM_IRQ] = im_r;
                rdata_s[EXL]               = exl_r;
                rdata_s[IE]                = ie_r;
            end
            SEL_CAUSE: begin
                rdata_s[IP_LSB +: NUM_IRQ] = ip_s;
                rdata_s[ID_LSB +: 4]       = id_r;
            end
            SEL_EPC:   rdata_s = 32'(epc_r);
            SEL_PRID:  rdata_s = PRID;
            SEL_ITRIG: rdata_s[NUM_IRQ-1:0] = itrig_r;
            default:   rdata_s = 32'h0000_0000;
        endcase
    end

    assign bus.rdata  = rdata_s;
    assign bus.epc    = epc_r;
    assign bus.intreq = any_s & ie_r & ~exl_r;
    assign bus.irq_id = id_s;
    assign bus.vector = (VECTORED != 0)
                      ? HANDLER_BASE + (PC_W'(id_s) << VEC_SHIFT)
                      : HANDLER_BASE;

endmodule

// File: tb/tb_cp0_intc.sv
// Scenario bench for cp0_intc (vectored build): each task queues its
// expected values as it drives stimulus and pops them at observation.
module tb_cp0_intc;
    import cp0_pkg::*;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [31:0] exp_q[$];
    logic [31:0] obs;
    logic [31:0] exp_v;

    cp0_intc_if #(.NUM_IRQ(6), .PC_W(32)) bus ();

    cp0_intc #(
        .NUM_IRQ      (6),
        .PC_W         (32),
        .HANDLER_BASE (32'h0000_4180),
        .VECTORED     (1),
        .VEC_SHIFT    (4),
        .TRIG_RESET   (6'b000000),
        .PRID         (32'h0000_0001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
        bus.sel = s; bus.wdata = d; bus.we = 1'b1;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] s, output logic [31:0] v);
        bus.sel = s;
        #1;
        v = bus.rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pc_in = 32'h0; bus.wdata = 32'h0; bus.hwint = 6'h0; bus.sel = 5'd0;
        bus.we = 1'b0; bus.exl_set = 1'b0; bus.exl_clr = 1'b0; bus.epc_wr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4180); exp_q.push_back(32'h0);
        tick();
        rd(SEL_SR, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL reset_sr: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_CAUSE, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL reset_cause: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_EPC, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL reset_epc: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_PRID, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL reset_prid: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_ITRIG, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL reset_itrig: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL reset_intreq: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.irq_id); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL reset_irq_id: got %h expected %h", obs, exp_v); else n_pass++;
        obs = bus.vector; exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL reset_vector: got %h expected %h", obs, exp_v); else n_pass++;
        mtc0(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL unmapped_sel: got %h expected %h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_level();
        exp_q.push_back(32'h0000_FC01);
        mtc0(SEL_SR, 32'h0000_FC01);
        rd(SEL_SR, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL sr_write: got %h expected %h", obs, exp_v); else n_pass++;
        exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h2);
        exp_q.push_back(32'h41A0); exp_q.push_back(32'h1000);
        bus.hwint[2] = 1'b1;
        tick();
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL level_rise_early: got %h expected %h", obs, exp_v); else n_pass++;
        tick();
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL level_rise: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.irq_id); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL level_irq_id: got %h expected %h", obs, exp_v); else n_pass++;
        obs = bus.vector; exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL level_vector: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_CAUSE, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL level_cause: got %h expected %h", obs, exp_v); else n_pass++;
        exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        bus.hwint[2] = 1'b0;
        tick();
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL level_fall_early: got %h expected %h", obs, exp_v); else n_pass++;
        tick();
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL level_fall: got %h expected %h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_edge();
        exp_q.push_back(32'h1);
        mtc0(SEL_ITRIG, 32'h0000_0001);
        rd(SEL_ITRIG, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL itrig_write: got %h expected %h", obs, exp_v); else n_pass++;
        exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        exp_q.push_back(32'h1); exp_q.push_back(32'h400);
        bus.hwint[0] = 1'b1;
        tick();
        bus.hwint[0] = 1'b0;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL edge_early: got %h expected %h", obs, exp_v); else n_pass++;
        tick();
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL edge_set: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.irq_id); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL edge_irq_id: got %h expected %h", obs, exp_v); else n_pass++;
        repeat (3) tick();
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL edge_sticky: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_CAUSE, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL edge_cause: got %h expected %h", obs, exp_v); else n_pass++;
        // interrupt entry with an unaligned PC
        exp_q.push_back(32'h3010); exp_q.push_back(32'h3010); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        bus.pc_in = 32'h0000_3013; bus.epc_wr = 1'b1;
        tick();
        bus.epc_wr = 1'b0;
        rd(SEL_EPC, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL entry_epc_rd: got %h expected %h", obs, exp_v); else n_pass++;
        obs = bus.epc; exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL entry_epc_port: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_CAUSE, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL entry_cause: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL entry_intreq: got %h expected %h", obs, exp_v); else n_pass++;
        // new edge lands on the same clock as a write-1-to-clear: edge wins
        exp_q.push_back(32'h400); exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        bus.hwint[0] = 1'b1;
        tick();
        bus.hwint[0] = 1'b0;
        mtc0(SEL_CAUSE, 32'h0000_0400);
        rd(SEL_CAUSE, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL edge_beats_clear: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL edge_beats_clear_req: got %h expected %h", obs, exp_v); else n_pass++;
        mtc0(SEL_CAUSE, 32'h0000_0400);
        rd(SEL_CAUSE, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL w1c_cause: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL w1c_intreq: got %h expected %h", obs, exp_v); else n_pass++;
        mtc0(SEL_ITRIG, 32'h0);
    endtask

    task automatic test_priority();
        exp_q.push_back(32'h1); exp_q.push_back(32'h4190); exp_q.push_back(32'h4); exp_q.push_back(32'h41C0);
        bus.hwint = 6'b010010;
        repeat (2) tick();
        obs = 32'(bus.irq_id); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL prio_both: got %h expected %h", obs, exp_v); else n_pass++;
        obs = bus.vector; exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL prio_vector1: got %h expected %h", obs, exp_v); else n_pass++;
        mtc0(SEL_SR, 32'h0000_F401);
        obs = 32'(bus.irq_id); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL prio_masked: got %h expected %h", obs, exp_v); else n_pass++;
        obs = bus.vector; exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL prio_vector4: got %h expected %h", obs, exp_v); else n_pass++;
        // entry concurrent with an mtc0 to EPC: entry wins; level source stays
        exp_q.push_back(32'h2004); exp_q.push_back(32'h4000_4800); exp_q.push_back(32'h1);
        bus.pc_in = 32'h0000_2004; bus.epc_wr = 1'b1;
        bus.sel = SEL_EPC; bus.wdata = 32'h5555_5554; bus.we = 1'b1;
        tick();
        bus.epc_wr = 1'b0; bus.we = 1'b0;
        obs = bus.epc; exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL epc_conflict: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_CAUSE, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL cause_id4: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL level_not_cleared: got %h expected %h", obs, exp_v); else n_pass++;
        bus.hwint = 6'b000000;
        repeat (2) tick();
    endtask

    task automatic test_exl();
        mtc0(SEL_SR, 32'h0000_FC01);
        exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h0000_FC03);
        bus.hwint[2] = 1'b1;
        repeat (2) tick();
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL exl_pre: got %h expected %h", obs, exp_v); else n_pass++;
        bus.exl_set = 1'b1;
        tick();
        bus.exl_set = 1'b0;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL exl_blocks: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_SR, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL exl_sr: got %h expected %h", obs, exp_v); else n_pass++;
        exp_q.push_back(32'h0000_FC03); exp_q.push_back(32'h4000_3000); exp_q.push_back(32'h0);
        bus.exl_set = 1'b1; bus.exl_clr = 1'b1;
        tick();
        bus.exl_set = 1'b0; bus.exl_clr = 1'b0;
        rd(SEL_SR, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL exl_set_wins: got %h expected %h", obs, exp_v); else n_pass++;
        mtc0(SEL_ITRIG, 32'h0000_0008);
        bus.hwint[3] = 1'b1;
        tick();
        bus.hwint[3] = 1'b0;
        tick();
        rd(SEL_CAUSE, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL exl_accumulate: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL exl_accum_req: got %h expected %h", obs, exp_v); else n_pass++;
        exp_q.push_back(32'h1); exp_q.push_back(32'h2);
        bus.exl_clr = 1'b1;
        tick();
        bus.exl_clr = 1'b0;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL exl_clr_req: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.irq_id); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL exl_clr_id: got %h expected %h", obs, exp_v); else n_pass++;
        // SR write alongside exl_set: written fields apply, EXL ends up set
        exp_q.push_back(32'h0000_0403); exp_q.push_back(32'h0000_0401); exp_q.push_back(32'h0);
        bus.sel = SEL_SR; bus.wdata = 32'h0000_0401; bus.we = 1'b1; bus.exl_set = 1'b1;
        tick();
        bus.we = 1'b0; bus.exl_set = 1'b0;
        rd(SEL_SR, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL sr_with_exl_set: got %h expected %h", obs, exp_v); else n_pass++;
        bus.exl_clr = 1'b1;
        tick();
        bus.exl_clr = 1'b0;
        rd(SEL_SR, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL sr_after_clr: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL masked_req: got %h expected %h", obs, exp_v); else n_pass++;
        bus.hwint = 6'b000000;
        mtc0(SEL_CAUSE, 32'h0000_2000);
        mtc0(SEL_ITRIG, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid();
        mtc0(SEL_SR, 32'h0000_FC01);
        mtc0(SEL_EPC, 32'h0000_1237);
        mtc0(SEL_ITRIG, 32'h0000_0008);
        exp_q.push_back(32'h1234); exp_q.push_back(32'h1); exp_q.push_back(32'h3);
        bus.hwint[3] = 1'b1;
        tick();
        bus.hwint[3] = 1'b0;
        tick();
        obs = bus.epc; exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL epc_mtc0_align: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL pre_rst_req: got %h expected %h", obs, exp_v); else n_pass++;
        obs = 32'(bus.irq_id); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL pre_rst_id: got %h expected %h", obs, exp_v); else n_pass++;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h4180);
        #2;
        rst = 1'b1;
        #1;
        obs = 32'(bus.intreq); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL async_rst_req: got %h expected %h", obs, exp_v); else n_pass++;
        obs = bus.epc; exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL async_rst_epc: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_CAUSE, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL async_rst_cause: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_SR, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL async_rst_sr: got %h expected %h", obs, exp_v); else n_pass++;
        rd(SEL_ITRIG, obs); exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL async_rst_itrig: got %h expected %h", obs, exp_v); else n_pass++;
        obs = bus.vector; exp_v = exp_q.pop_front(); n_total++;
        if (obs !== exp_v) $display("FAIL async_rst_vector: got %h expected %h", obs, exp_v); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_level();
        test_edge();
        test_priority();
        test_exl();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
